// File: rtl/avs_hram_arb_pkg.sv
// Shared types and helpers for the two-master HyperRAM Avalon arbiter.
// The depth check is evaluated at elaboration by the top level.
package avs_hram_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Master index: 0 or 1
   typedef logic owner_t;

   localparam int PEND_DEPTH_DFLT = 4;

   function automatic bit pend_depth_ok(input int depth);
      return (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/avs_hram_arbiter_if.sv
// Avalon-MM word-access bus bundle. The master modport issues commands and
// the slave modport answers them, including pipelined read returns.
interface avs_hram_arbiter_if #(
   parameter int ADDR_W = 22,
   parameter int DATA_W = 16
) ();

   logic [ADDR_W-1:0]   address;
   logic                read;
   logic                write;
   logic [DATA_W-1:0]   writedata;
   logic [DATA_W/8-1:0] byteenable;
   logic                waitrequest;
   logic [DATA_W-1:0]   readdata;
   logic                readdatavalid;

   modport master (
      output address, read, write, writedata, byteenable,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, read, write, writedata, byteenable,
      output waitrequest, readdata, readdatavalid
   );

endinterface

// File: rtl/avs_hram_arbiter_id_fifo.sv
// Small synchronous FIFO of 1-bit master IDs, one entry per outstanding read.
// A push is accepted while full only when a pop happens on the same edge.
module hram_arb_id_fifo #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  logic din,
   input  logic pop,
   output logic head,
   output logic full,
   output logic empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [DEPTH-1:0] mem_q, mem_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;

   always_comb begin
      do_pop   = pop & (cnt_q != '0);
      do_push  = push & ((cnt_q != FULL_CNT) | do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign full  = (cnt_q == FULL_CNT);
   assign empty = (cnt_q == '0);

endmodule

// File: rtl/avs_hram_arbiter.sv
// Round-robin arbiter letting two Avalon masters share one HyperRAM converter.
// One command per grant; read IDs are queued so returns reach the issuer.
module avs_hram_arbiter
   import avs_hram_arb_pkg::*;
#(
   parameter int ADDR_W     = 22,
   parameter int DATA_W     = 16,
   parameter int PEND_DEPTH = PEND_DEPTH_DFLT
) (
   input  logic                 clk,
   input  logic                 reset,
   avs_hram_arbiter_if.slave    m0,
   avs_hram_arbiter_if.slave    m1,
   avs_hram_arbiter_if.master   s,
   output logic                 rdv_error
);

   if (!pend_depth_ok(PEND_DEPTH)) begin : g_depth_chk
      $error("avs_hram_arbiter: PEND_DEPTH must be a power of 2 and >= 2");
   end

   arb_state_t state_q, state_d;
   owner_t     owner_q, owner_d;
   owner_t     last_grant_q, last_grant_d;
   logic       rdv_error_q, rdv_error_d;

   logic [1:0] rd_req, wr_req, req;
   logic       fifo_full, fifo_empty, fifo_head;
   logic       push, pop, accept;

   logic [ADDR_W-1:0]   mux_addr;
   logic [DATA_W-1:0]   mux_wdata;
   logic [DATA_W/8-1:0] mux_be;
   logic                mux_rd, mux_wr;

   // Read wins when a master illegally asserts both; full FIFO masks reads only.
   always_comb begin
      rd_req = {m1.read, m0.read};
      wr_req = {m1.write & ~m1.read, m0.write & ~m0.read};
      req    = (rd_req & {2{~fifo_full}}) | wr_req;
   end

   always_comb begin
      mux_addr  = owner_q ? m1.address    : m0.address;
      mux_wdata = owner_q ? m1.writedata  : m0.writedata;
      mux_be    = owner_q ? m1.byteenable : m0.byteenable;
      mux_rd    = (state_q == GRANT) & rd_req[owner_q];
      mux_wr    = (state_q == GRANT) & wr_req[owner_q];
   end

   assign accept = (mux_rd | mux_wr) & ~s.waitrequest;
   assign push   = accept & mux_rd;
   assign pop    = s.readdatavalid & ~fifo_empty;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      rdv_error_d  = rdv_error_q | (s.readdatavalid & fifo_empty);
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = GRANT;
               owner_d = (&req) ? ~last_grant_q : req[1];
            end
         end
         GRANT: begin
            if (accept) begin
               state_d      = IDLE;
               last_grant_d = owner_q;
            end else if (!(mux_rd | mux_wr)) begin
               // Owner withdrew its command; do not hold the bus for it.
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         rdv_error_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         rdv_error_q  <= rdv_error_d;
      end
   end

   hram_arb_id_fifo #(.DEPTH(PEND_DEPTH)) u_id_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (owner_q),
      .pop   (pop),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign s.address    = mux_addr;
   assign s.read       = mux_rd;
   assign s.write      = mux_wr;
   assign s.writedata  = mux_wdata;
   assign s.byteenable = mux_be;

   assign m0.waitrequest = ~(accept & (owner_q == 1'b0));
   assign m1.waitrequest = ~(accept & (owner_q == 1'b1));

   assign m0.readdata      = s.readdata;
   assign m1.readdata      = s.readdata;
   assign m0.readdatavalid = pop & (fifo_head == 1'b0);
   assign m1.readdatavalid = pop & (fifo_head == 1'b1);

   assign rdv_error = rdv_error_q;

endmodule

// File: tb/tb_avs_hram_arbiter.sv
// Directed latency/ordering scenarios plus a randomized two-master run scored
// against a queue model of grants, outstanding reads and in-order returns.
module tb_avs_hram_arbiter;

   localparam int AW = 22;
   localparam int DW = 16;
   localparam int PD = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic rdv_error;
   int   n_tests = 0;
   int   n_fail = 0;

   avs_hram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
   avs_hram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();
   avs_hram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) s_if ();

   avs_hram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PEND_DEPTH(PD)) dut (
      .clk       (clk),
      .reset     (reset),
      .m0        (m0_if),
      .m1        (m1_if),
      .s         (s_if),
      .rdv_error (rdv_error)
   );

   always #5 clk = ~clk;

   typedef struct { logic [DW-1:0] d; int due; } ret_t;
   ret_t          ret_q[$];
   bit            own_q[$];
   int            cyc_n = 0;
   int            last_due = 0;
   logic [DW-1:0] cur_data = '0;
   bit            done0 = 0, done1 = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int mi, input logic rd, input logic wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
      if (mi == 0) begin
         m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
         m0_if.writedata = d; m0_if.byteenable = be;
      end else begin
         m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
         m1_if.writedata = d; m1_if.byteenable = be;
      end
   endtask

   function automatic logic get_wr(input int mi);
      return (mi == 0) ? m0_if.waitrequest : m1_if.waitrequest;
   endfunction

   // Issue one command and hold it until accepted (bounded), then drop it.
   task automatic xfer(input int mi, input logic rd, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [1:0] be);
      bit got;
      got = 0;
      cyc();
      set_req(mi, rd, !rd, a, d, be);
      for (int w = 0; w < 300 && !got; w++) begin
         @(negedge clk);
         if (get_wr(mi) == 1'b0) got = 1;
      end
      chk("xfer_accept", 32'(got), 32'(1));
      cyc();
      set_req(mi, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic ret(input logic [DW-1:0] d, input int mi);
      cyc();
      s_if.readdatavalid = 1'b1;
      s_if.readdata = d;
      @(negedge clk);
      chk("ret_m0_rdv", 32'(m0_if.readdatavalid), 32'(mi == 0));
      chk("ret_m1_rdv", 32'(m1_if.readdatavalid), 32'(mi == 1));
      chk("ret_data", 32'((mi == 0) ? m0_if.readdata : m1_if.readdata), 32'(d));
      cyc();
      s_if.readdatavalid = 1'b0;
   endtask

   task automatic master_run(input int mi, input int n);
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(0, 3)) cyc();
         xfer(mi, 1'($urandom), AW'($urandom), DW'($urandom), 2'($urandom_range(1, 3)));
      end
   endtask

   // Scoreboard plus slave model: random stalls, in-order returns with random latency.
   task automatic mon_run();
      int fair[2];
      fair[0] = 0; fair[1] = 0;
      while (!(done0 && done1 && own_q.size() == 0) && cyc_n < 20000) begin
         logic w0, w1, acc;
         bit   o;
         @(negedge clk);
         cyc_n++;
         w0  = m0_if.waitrequest;
         w1  = m1_if.waitrequest;
         acc = (s_if.read | s_if.write) & !s_if.waitrequest;
         o   = !w1;
         chk("excl_grant", 32'(!w0 && !w1), 32'(0));
         chk("no_rd_and_wr", 32'(s_if.read && s_if.write), 32'(0));
         if (!w0 || !w1) chk("wr_low_means_accept", 32'(acc), 32'(1));
         if (s_if.readdatavalid) begin
            if (own_q.size() != 0) begin
               bit eo;
               eo = own_q.pop_front();
               chk("rdv_m0", 32'(m0_if.readdatavalid), 32'(eo == 0));
               chk("rdv_m1", 32'(m1_if.readdatavalid), 32'(eo == 1));
               chk("rdv_data", 32'(eo ? m1_if.readdata : m0_if.readdata), 32'(cur_data));
            end
         end else if (m0_if.readdatavalid || m1_if.readdatavalid) begin
            chk("rdv_stray", 32'(m0_if.readdatavalid | m1_if.readdatavalid), 32'(0));
         end
         if (acc) begin
            logic          er, ew;
            logic [AW-1:0] ea;
            logic [DW-1:0] ed;
            logic [1:0]    eb;
            chk("acc_one_grant", 32'(!w0) + 32'(!w1), 32'(1));
            er = o ? m1_if.read : m0_if.read;
            ew = o ? (m1_if.write & !m1_if.read) : (m0_if.write & !m0_if.read);
            ea = o ? m1_if.address : m0_if.address;
            ed = o ? m1_if.writedata : m0_if.writedata;
            eb = o ? m1_if.byteenable : m0_if.byteenable;
            chk("fwd_read", 32'(s_if.read), 32'(er));
            chk("fwd_write", 32'(s_if.write), 32'(ew));
            chk("fwd_addr", 32'(s_if.address), 32'(ea));
            if (ew) begin
               chk("fwd_wdata", 32'(s_if.writedata), 32'(ed));
               chk("fwd_be", 32'(s_if.byteenable), 32'(eb));
            end
            if (s_if.read) begin
               ret_t r;
               own_q.push_back(o);
               r.d = DW'($urandom);
               r.due = cyc_n + $urandom_range(1, 12);
               if (r.due <= last_due) r.due = last_due + 1;
               last_due = r.due;
               ret_q.push_back(r);
               chk("pend_limit", 32'(own_q.size() <= PD), 32'(1));
            end
         end
         for (int i = 0; i < 2; i++) begin
            logic reqw;
            reqw = (i == 0) ? (m0_if.write & !m0_if.read) : (m1_if.write & !m1_if.read);
            if (!reqw) fair[i] = 0;
            else if (acc && o != 1'(i)) fair[i]++;
            else if (acc) begin
               chk("fair_write", 32'(fair[i] <= 1), 32'(1));
               fair[i] = 0;
            end
         end
         cyc();
         s_if.waitrequest = ($urandom_range(0, 2) == 0);
         if (ret_q.size() != 0 && ret_q[0].due <= cyc_n) begin
            s_if.readdatavalid = 1'b1;
            s_if.readdata = ret_q[0].d;
            cur_data = ret_q[0].d;
            void'(ret_q.pop_front());
         end else begin
            s_if.readdatavalid = 1'b0;
            s_if.readdata = DW'($urandom);
         end
      end
      chk("rand_drained", 32'(own_q.size()), 32'(0));
      chk("rand_in_budget", 32'(cyc_n < 20000), 32'(1));
      s_if.waitrequest = 1'b0;
      s_if.readdatavalid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      set_req(0, 0, 0, '0, '0, '0);
      set_req(1, 0, 0, '0, '0, '0);
      s_if.waitrequest = 1'b0;
      s_if.readdata = '0;
      s_if.readdatavalid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_m0_wr", 32'(m0_if.waitrequest), 32'(1));
      chk("rst_m1_wr", 32'(m1_if.waitrequest), 32'(1));
      chk("rst_s_cmd", 32'(s_if.read | s_if.write), 32'(0));
      chk("rst_rdv", 32'(m0_if.readdatavalid | m1_if.readdatavalid), 32'(0));
      chk("rst_err", 32'(rdv_error), 32'(0));
      cyc();
      reset = 1'b0;

      // Tie from reset: m0 first, then m1.
      cyc();
      set_req(0, 1, 0, 22'h100, '0, 2'b11);
      set_req(1, 1, 0, 22'h200, '0, 2'b11);
      @(negedge clk);
      chk("tie1_idle", 32'(s_if.read), 32'(0));
      cyc(); @(negedge clk);
      chk("tie1_m0_first", 32'(m0_if.waitrequest), 32'(0));
      chk("tie1_m1_wait", 32'(m1_if.waitrequest), 32'(1));
      chk("tie1_addr0", 32'(s_if.address), 32'(22'h100));
      cyc();
      set_req(0, 0, 0, '0, '0, '0);
      @(negedge clk);
      chk("tie1_gap", 32'(s_if.read), 32'(0));
      cyc(); @(negedge clk);
      chk("tie1_m1_second", 32'(m1_if.waitrequest), 32'(0));
      chk("tie1_addr1", 32'(s_if.address), 32'(22'h200));
      cyc();
      set_req(1, 0, 0, '0, '0, '0);
      ret(16'h5A5A, 0);
      ret(16'hA5A5, 1);

      // m0 write stalled three cycles by the converter.
      s_if.waitrequest = 1'b1;
      cyc();
      set_req(0, 0, 1, 22'h00010, 16'hBEEF, 2'b11);
      @(negedge clk);
      chk("w_idle", 32'(s_if.write), 32'(0));
      for (int k = 0; k < 3; k++) begin
         cyc(); @(negedge clk);
         chk("w_hold_s_wr", 32'(s_if.write), 32'(1));
         chk("w_hold_m0_wr", 32'(m0_if.waitrequest), 32'(1));
         chk("w_hold_m1_wr", 32'(m1_if.waitrequest), 32'(1));
         if (k == 0) begin
            chk("w_addr", 32'(s_if.address), 32'(22'h00010));
            chk("w_data", 32'(s_if.writedata), 32'(16'hBEEF));
            chk("w_be", 32'(s_if.byteenable), 32'(2'b11));
         end
      end
      cyc();
      s_if.waitrequest = 1'b0;
      @(negedge clk);
      chk("w_acc_m0", 32'(m0_if.waitrequest), 32'(0));
      chk("w_acc_m1", 32'(m1_if.waitrequest), 32'(1));
      chk("w_acc_s_wr", 32'(s_if.write), 32'(1));
      cyc();
      set_req(0, 0, 0, '0, '0, '0);
      @(negedge clk);
      chk("w_after", 32'(s_if.write), 32'(0));

      // Second tie after an m0 grant goes to m1.
      cyc();
      set_req(0, 0, 1, 22'h300, 16'h1234, 2'b11);
      set_req(1, 0, 1, 22'h400, 16'h5678, 2'b11);
      cyc(); @(negedge clk);
      chk("tie2_m1_first", 32'(m1_if.waitrequest), 32'(0));
      chk("tie2_m0_wait", 32'(m0_if.waitrequest), 32'(1));
      chk("tie2_wdata", 32'(s_if.writedata), 32'(16'h5678));
      cyc();
      set_req(1, 0, 0, '0, '0, '0);
      cyc(); @(negedge clk);
      chk("tie2_m0_second", 32'(m0_if.waitrequest), 32'(0));
      chk("tie2_addr", 32'(s_if.address), 32'(22'h300));
      cyc();
      set_req(0, 0, 0, '0, '0, '0);

      // Four outstanding m1 reads fill the ID queue.
      for (int k = 0; k < 4; k++) xfer(1, 1'b1, AW'(22'h1000 + k), '0, 2'b11);
      cyc();
      set_req(1, 1, 0, 22'h2000, '0, 2'b11);
      set_req(0, 0, 1, 22'h3000, 16'hCAFE, 2'b11);
      @(negedge clk);
      chk("full_idle", 32'(s_if.read | s_if.write), 32'(0));
      cyc(); @(negedge clk);
      chk("full_wr_grant", 32'(s_if.write), 32'(1));
      chk("full_m0_acc", 32'(m0_if.waitrequest), 32'(0));
      chk("full_rd_held", 32'(s_if.read), 32'(0));
      cyc();
      set_req(0, 0, 0, '0, '0, '0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("full_rd_masked", 32'(s_if.read), 32'(0));
         chk("full_m1_wait", 32'(m1_if.waitrequest), 32'(1));
         cyc();
      end
      s_if.readdatavalid = 1'b1;
      s_if.readdata = 16'hAAAA;
      @(negedge clk);
      chk("full_pop_m1", 32'(m1_if.readdatavalid), 32'(1));
      chk("full_pop_data", 32'(m1_if.readdata), 32'(16'hAAAA));
      chk("full_pop_m0", 32'(m0_if.readdatavalid), 32'(0));
      cyc();
      s_if.readdatavalid = 1'b0;
      @(negedge clk);
      chk("full_regrant_idle", 32'(s_if.read), 32'(0));
      cyc(); @(negedge clk);
      chk("full_5th_issue", 32'(s_if.read), 32'(1));
      chk("full_5th_acc", 32'(m1_if.waitrequest), 32'(0));
      chk("full_5th_addr", 32'(s_if.address), 32'(22'h2000));
      cyc();
      set_req(1, 0, 0, '0, '0, '0);
      for (int k = 0; k < 4; k++) ret(DW'(16'h0100 + k), 1);

      // Interleaved reads return to their issuers.
      xfer(0, 1'b1, 22'h11, '0, 2'b11);
      xfer(1, 1'b1, 22'h22, '0, 2'b11);
      xfer(0, 1'b1, 22'h33, '0, 2'b11);
      ret(16'h1111, 0);
      ret(16'h2222, 1);
      ret(16'h3333, 0);

      fork
         begin master_run(0, 60); done0 = 1; end
         begin master_run(1, 60); done1 = 1; end
         mon_run();
      join

      // Return strobe with nothing pending.
      cyc();
      s_if.readdatavalid = 1'b1;
      s_if.readdata = 16'hDEAD;
      @(negedge clk);
      chk("spur_m0", 32'(m0_if.readdatavalid), 32'(0));
      chk("spur_m1", 32'(m1_if.readdatavalid), 32'(0));
      chk("spur_err_pre", 32'(rdv_error), 32'(0));
      cyc();
      s_if.readdatavalid = 1'b0;
      @(negedge clk);
      chk("spur_err", 32'(rdv_error), 32'(1));
      repeat (3) cyc();
      @(negedge clk);
      chk("spur_err_sticky", 32'(rdv_error), 32'(1));

      // Reset while a write is on the bus, with one read outstanding.
      xfer(0, 1'b1, 22'h50, '0, 2'b11);
      s_if.waitrequest = 1'b1;
      cyc();
      set_req(0, 0, 1, 22'h60, 16'h6666, 2'b11);
      cyc(); @(negedge clk);
      chk("rstx_s_wr_pre", 32'(s_if.write), 32'(1));
      #2 reset = 1'b1;
      #1;
      chk("rstx_s_wr", 32'(s_if.write), 32'(0));
      chk("rstx_m0_wr", 32'(m0_if.waitrequest), 32'(1));
      chk("rstx_m1_wr", 32'(m1_if.waitrequest), 32'(1));
      chk("rstx_err_clr", 32'(rdv_error), 32'(0));
      set_req(0, 0, 0, '0, '0, '0);
      s_if.waitrequest = 1'b0;
      cyc();
      reset = 1'b0;
      cyc();
      s_if.readdatavalid = 1'b1;
      s_if.readdata = 16'h7777;
      @(negedge clk);
      chk("rstx_fifo_empty", 32'(m0_if.readdatavalid), 32'(0));
      cyc();
      s_if.readdatavalid = 1'b0;
      @(negedge clk);
      chk("rstx_err_set", 32'(rdv_error), 32'(1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
